// File: rtl/div_pkg.sv
// Shared types and default widths for the sequential restoring divider.
package div_pkg;

    localparam int DIV_DIVIDEND_W = 8;
    localparam int DIV_DIVISOR_W  = 4;
    localparam int CNT_W          = $clog2(DIV_DIVIDEND_W);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_e;

endpackage

// File: rtl/div_if.sv
// Start/done handshake and operand/result bus between a control FSM and the divider.
interface div_if #(
    parameter int DIVIDEND_W = div_pkg::DIV_DIVIDEND_W,
    parameter int DIVISOR_W  = div_pkg::DIV_DIVISOR_W
);
    logic                  start_i;
    logic [DIVIDEND_W-1:0] dividend_i;
    logic [DIVISOR_W-1:0]  divisor_i;
    logic                  busy_o;
    logic                  done_o;
    logic [DIVIDEND_W-1:0] quotient_o;
    logic [DIVISOR_W-1:0]  remainder_o;
    logic                  div_by_zero_o;

    modport master (
        output start_i, dividend_i, divisor_i,
        input  busy_o, done_o, quotient_o, remainder_o, div_by_zero_o
    );

    modport slave (
        input  start_i, dividend_i, divisor_i,
        output busy_o, done_o, quotient_o, remainder_o, div_by_zero_o
    );
endinterface

// File: rtl/div_step.sv
// One restoring-division iteration: shift in a dividend bit, trial-subtract the divisor.
module div_step #(
    parameter int DIVISOR_W = div_pkg::DIV_DIVISOR_W
) (
    input  logic [DIVISOR_W:0]   rem,
    input  logic                 din,
    input  logic [DIVISOR_W-1:0] divisor,
    output logic [DIVISOR_W:0]   rem_nxt,
    output logic                 q_bit
);
    logic [DIVISOR_W:0] shifted;
    logic [DIVISOR_W:0] diff;
    logic               rem_msb_unused;

    // The MSB is shifted out; it is always 0 after a restoring step anyway.
    assign rem_msb_unused = rem[DIVISOR_W];
    assign shifted        = {rem[DIVISOR_W-1:0], din};
    assign diff           = shifted - {1'b0, divisor};
    assign q_bit          = (shifted >= {1'b0, divisor});
    assign rem_nxt        = q_bit ? diff : shifted;
endmodule

// File: rtl/div_8by4_seq.sv
// Sequential restoring divider: one quotient bit per clock, start/done handshake.
module div_8by4_seq
    import div_pkg::*;
#(
    parameter int DIVIDEND_W = DIV_DIVIDEND_W,
    parameter int DIVISOR_W  = DIV_DIVISOR_W
) (
    input  logic clk_i,
    input  logic rst_i,
    div_if.slave bus
);
    localparam int CW = $clog2(DIVIDEND_W);

    div_state_e            state, state_nxt;
    logic [CW-1:0]         cnt;
    logic [DIVIDEND_W-1:0] dvd_sh;
    logic [DIVIDEND_W-1:0] quo_sh;
    logic [DIVISOR_W:0]    rem;
    logic [DIVISOR_W-1:0]  dsr;
    logic [DIVISOR_W:0]    rem_nxt;
    logic                  q_bit;
    logic                  accept;
    logic                  last;
    logic [DIVIDEND_W-1:0] quo_nxt;

    div_step #(.DIVISOR_W(DIVISOR_W)) u_step (
        .rem     (rem),
        .din     (dvd_sh[DIVIDEND_W-1]),
        .divisor (dsr),
        .rem_nxt (rem_nxt),
        .q_bit   (q_bit)
    );

    assign quo_nxt = {quo_sh[DIVIDEND_W-2:0], q_bit};

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        last      = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start_i) begin
                    accept    = 1'b1;
                    // A zero divisor skips the iterations entirely.
                    state_nxt = (bus.divisor_i == '0) ? DONE : CALC;
                end
            end
            CALC: begin
                if (cnt == '0) begin
                    last      = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state <= IDLE;
        else       state <= state_nxt;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt               <= '0;
            dvd_sh            <= '0;
            quo_sh            <= '0;
            rem               <= '0;
            dsr               <= '0;
            bus.busy_o        <= 1'b0;
            bus.done_o        <= 1'b0;
            bus.quotient_o    <= '0;
            bus.remainder_o   <= '0;
            bus.div_by_zero_o <= 1'b0;
        end else begin
            // Status flags track the state being entered, so they are glitch-free registers.
            bus.busy_o <= (state_nxt != IDLE);
            bus.done_o <= (state_nxt == DONE);
            if (accept) begin
                dvd_sh <= bus.dividend_i;
                dsr    <= bus.divisor_i;
                cnt    <= CW'(DIVIDEND_W - 1);
                rem    <= '0;
                quo_sh <= '0;
                if (bus.divisor_i == '0) begin
                    bus.quotient_o    <= '1;
                    bus.remainder_o   <= '0;
                    bus.div_by_zero_o <= 1'b1;
                end
            end else if (state == CALC) begin
                rem    <= rem_nxt;
                dvd_sh <= {dvd_sh[DIVIDEND_W-2:0], 1'b0};
                quo_sh <= quo_nxt;
                if (last) begin
                    bus.quotient_o    <= quo_nxt;
                    bus.remainder_o   <= rem_nxt[DIVISOR_W-1:0];
                    bus.div_by_zero_o <= 1'b0;
                end else begin
                    cnt <= cnt - 1'b1;
                end
            end
        end
    end
endmodule

// File: doc/div_8by4_seq.md
Name: div_8by4_seq

Overview:
Sequential restoring divider that inverts the 4x4 array multiplier. It takes an 8-bit dividend and a 4-bit divisor and returns an 8-bit quotient and a 4-bit remainder, one quotient bit per clock. It sits beside the multiplier in the arithmetic helpers and uses a start/done handshake so a control FSM can drive it.

Parameters:
DIVIDEND_W, 8, dividend and quotient width in bits
DIVISOR_W, 4, divisor and remainder width in bits

Ports:
clk_i  input  1  clock, rising edge
rst_i  input  1  asynchronous reset, active-high
start_i  input  1  request a division; accepted only when busy_o=0
dividend_i  input  DIVIDEND_W  dividend, sampled on the accepted start
divisor_i  input  DIVISOR_W  divisor, sampled on the accepted start
busy_o  output  1  high from the cycle after an accepted start until done_o
done_o  output  1  one-cycle pulse: results valid
quotient_o  output  DIVIDEND_W  quotient, held until the next accepted start
remainder_o  output  DIVISOR_W  remainder, held until the next accepted start
div_by_zero_o  output  1  divisor was 0; valid with done_o, held like the results

Behaviour:
- Reset (async assert, synchronous release): state=IDLE; busy_o=0, done_o=0, quotient_o=0, remainder_o=0, div_by_zero_o=0; all internal registers cleared.
- FSM states: IDLE, CALC, DONE.
- IDLE with start_i=1:
  - Capture operands and set the iteration counter to DIVIDEND_W-1.
  - Clear the partial remainder (DIVISOR_W+1 bits) and the quotient.
  - If divisor_i==0, go to DONE with quotient=all ones, remainder=0, div_by_zero=1.
  - Otherwise go to CALC.
- CALC, one iteration per cycle:
  - r = {r[DIVISOR_W-1:0], dividend MSB}; shift the dividend left by 1.
  - If r >= divisor, then r = r - divisor and the quotient LSB = 1; else the quotient LSB = 0. The quotient shifts left by 1 each cycle.
  - When the counter is 0, go to DONE; otherwise decrement the counter.
- DONE:
  - done_o=1 for exactly one cycle.
  - quotient_o, remainder_o and div_by_zero_o update on entry to DONE and hold afterwards.
  - Return to IDLE.
- Latency, start cycle = cycle 0:
  - Normal case: busy_o=1 in cycles 1..DIVIDEND_W+1; done_o=1 in cycle DIVIDEND_W+1 (cycle 9 by default).
  - Divide by zero: done_o in cycle 1.
- busy_o=1 in CALC and DONE; busy_o=0 in IDLE.
- start_i while busy_o=1 (CALC or DONE) is ignored, with no queuing. The earliest next accept is the cycle after done_o.
- Result invariants: dividend = quotient*divisor + remainder; remainder < divisor. The quotient always fits in DIVIDEND_W bits because the divisor is at least 1.
- Remainder arithmetic runs at DIVISOR_W+1 bits so the compare never overflows. remainder_o is the low DIVISOR_W bits; the MSB is always 0 at completion.
- Reset mid-operation: abort immediately, return all outputs to their reset values, no done_o pulse.
- Output registers keep their old values during CALC; only the internal registers change.

Decomposition:
- div_pkg holds:
  - the state enum type div_state_e (IDLE, CALC, DONE);
  - localparams for the default widths;
  - the counter width constant CNT_W = $clog2(DIVIDEND_W).
- One sub-module, div_step: combinational single restoring iteration.
  - Inputs: partial remainder, incoming dividend bit, divisor.
  - Outputs: next partial remainder and quotient bit.
  - It is instantiated once and reused every cycle, the same way the adder is reused as a building block in the multiplier.
- The top level holds the FSM, counter, operand/quotient shift registers and output registers.

Test Plan:
- Normal division: dividend=200, divisor=7, start pulse -> done_o in cycle 9; quotient_o=28, remainder_o=4, div_by_zero_o=0; busy_o high in cycles 1..9.
- Extremes: 255/15 -> q=17, r=0. 255/1 -> q=255, r=0. 5/9 -> q=0, r=5. 0/3 -> q=0, r=0.
- Divide by zero: 77/0 -> done_o in cycle 1, quotient_o=8'hFF, remainder_o=0, div_by_zero_o=1. A following 9/2 -> q=4, r=1 and div_by_zero_o clears.
- Start while busy: start 100/3, then pulse start with 50/5 in cycle 4 -> second request ignored; results q=33, r=1; exactly one done_o.
- Reset mid-op: start 180/11, assert rst_i in cycle 5 -> outputs 0 and busy_o=0 immediately, no done_o. Restart 180/11 after release -> q=16, r=4.
- Exhaustive regression: all 256x16 operand pairs, back-to-back with start issued the cycle after each done_o -> every result satisfies the invariant. Divisor 0 flags div_by_zero_o.
